// File: rtl/dual_issue_buffer_pkg.sv
// Shared constants for the decode-stage dual-issue holding buffer:
// FSM state encodings, default widths and the canonical NOP word.
package dual_issue_buffer_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int ILEN_DEF  = 32;
  localparam int CNT_W_DEF = 16;

  // EMPTY: nothing held; FULL: both slots pending; HALF: only slot 2 pending.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_HALF  = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/dual_issue_buffer.sv
// Holds one fetched instruction pair in front of ID/EX and decides each cycle
// whether to issue both slots, slot 1 alone, slot 2 alone, or a bubble.
module dual_issue_buffer
  import dual_issue_buffer_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int ILEN  = ILEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [ILEN-1:0]  if_instr_1,
  input  logic [ILEN-1:0]  if_instr_2,
  output logic             if_ready,
  output logic [XLEN-1:0]  dec_pc,
  output logic [ILEN-1:0]  dec_instr_1,
  output logic [ILEN-1:0]  dec_instr_2,
  input  logic             stall_raw_1,
  input  logic             stall_raw_2,
  input  logic             pair_dep,
  output logic             iss_valid_1,
  output logic             iss_valid_2,
  output logic             iss_slot2_only,
  output logic [CNT_W-1:0] stall_cnt
);

  // Fetch handshake: a pair moves into the buffer on a rising edge exactly
  // when if_valid & if_ready; if_ready never depends on if_valid, and the
  // pair inputs are ignored whenever if_valid is low.

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [ILEN-1:0]  instr_1_q, instr_1_d;
  logic [ILEN-1:0]  instr_2_q, instr_2_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hold;
  logic load;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_1_d      = instr_1_q;
    instr_2_d      = instr_2_q;
    stall_cnt_d    = stall_cnt_q;
    iss_valid_1    = 1'b0;
    iss_valid_2    = 1'b0;
    iss_slot2_only = 1'b0;
    if_ready       = 1'b0;
    hold           = 1'b0;

    if (flush) begin
      state_d   = ST_EMPTY;
      instr_1_d = ILEN'(NOP_INSTR);
      instr_2_d = ILEN'(NOP_INSTR);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          // Stall inputs are meaningless here: dec_* hold NOP or stale words.
          if_ready = 1'b1;
          if (if_valid) state_d = ST_FULL;
        end
        ST_FULL: begin
          if (stall_raw_1) begin
            hold = 1'b1;
          end else if (stall_raw_2 || pair_dep) begin
            iss_valid_1 = 1'b1;
            state_d     = ST_HALF;
          end else begin
            iss_valid_1 = 1'b1;
            iss_valid_2 = 1'b1;
            if_ready    = 1'b1;
            state_d     = if_valid ? ST_FULL : ST_EMPTY;
          end
        end
        ST_HALF: begin
          if (stall_raw_2) begin
            hold = 1'b1;
          end else begin
            iss_valid_2    = 1'b1;
            iss_slot2_only = 1'b1;
            if_ready       = 1'b1;
            state_d        = if_valid ? ST_FULL : ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase

      if (hold && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    load = if_valid && if_ready;
    if (load) begin
      pc_d      = if_pc;
      instr_1_d = if_instr_1;
      instr_2_d = if_instr_2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      pc_q        <= '0;
      instr_1_q   <= ILEN'(NOP_INSTR);
      instr_2_q   <= ILEN'(NOP_INSTR);
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_1_q   <= instr_1_d;
      instr_2_q   <= instr_2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dec_pc      = pc_q;
  assign dec_instr_1 = instr_1_q;
  assign dec_instr_2 = instr_2_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_dual_issue_buffer.sv
// Directed plus randomized bench for dual_issue_buffer, checked against a
// queue-based model of which instruction slots are still waiting to issue.
module tb_dual_issue_buffer;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             if_valid;
  logic [XLEN-1:0]  if_pc;
  logic [ILEN-1:0]  if_instr_1;
  logic [ILEN-1:0]  if_instr_2;
  logic             if_ready;
  logic [XLEN-1:0]  dec_pc;
  logic [ILEN-1:0]  dec_instr_1;
  logic [ILEN-1:0]  dec_instr_2;
  logic             stall_raw_1;
  logic             stall_raw_2;
  logic             pair_dep;
  logic             iss_valid_1;
  logic             iss_valid_2;
  logic             iss_slot2_only;
  logic [CNT_W-1:0] stall_cnt;

  dual_issue_buffer #(.XLEN(XLEN), .ILEN(ILEN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr_1     (if_instr_1),
    .if_instr_2     (if_instr_2),
    .if_ready       (if_ready),
    .dec_pc         (dec_pc),
    .dec_instr_1    (dec_instr_1),
    .dec_instr_2    (dec_instr_2),
    .stall_raw_1    (stall_raw_1),
    .stall_raw_2    (stall_raw_2),
    .pair_dep       (pair_dep),
    .iss_valid_1    (iss_valid_1),
    .iss_valid_2    (iss_valid_2),
    .iss_slot2_only (iss_slot2_only),
    .stall_cnt      (stall_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: slots still awaiting issue, oldest first, plus the
  // words/PC last handed to the decoder and the saturating stall count.
  logic [1:0]  pend_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_i1;
  logic [31:0] m_i2;
  int          m_cnt;

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: apply inputs after the falling edge, check combinational outputs
  // and registers before the rising edge, then advance the model.
  task automatic step(input bit r, input bit f, input bit v, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit s1, input bit s2, input bit d);
    bit e_i1, e_i2, e_s2o, e_rdy, e_hold;
    rst = r; flush = f; if_valid = v; if_pc = pc; if_instr_1 = a; if_instr_2 = b;
    stall_raw_1 = s1; stall_raw_2 = s2; pair_dep = d;
    #1;
    e_i1 = 0; e_i2 = 0; e_s2o = 0; e_rdy = 0; e_hold = 0;
    if (!f) begin
      if (pend_q.size() == 0) begin
        e_rdy = 1;
      end else if (pend_q.size() == 2) begin
        if (s1) e_hold = 1;
        else if (s2 || d) e_i1 = 1;
        else begin e_i1 = 1; e_i2 = 1; e_rdy = 1; end
      end else begin
        if (s2) e_hold = 1;
        else begin e_i2 = 1; e_s2o = 1; e_rdy = 1; end
      end
    end
    if (!r) begin
      chk("iss_valid_1",    32'(iss_valid_1),    32'(e_i1));
      chk("iss_valid_2",    32'(iss_valid_2),    32'(e_i2));
      chk("iss_slot2_only", 32'(iss_slot2_only), 32'(e_s2o));
      chk("if_ready",       32'(if_ready),       32'(e_rdy));
      chk("dec_pc",         dec_pc,              m_pc);
      chk("dec_instr_1",    dec_instr_1,         m_i1);
      chk("dec_instr_2",    dec_instr_2,         m_i2);
      chk("stall_cnt",      32'(stall_cnt),      32'(m_cnt));
    end
    @(posedge clk);
    if (r) begin
      pend_q.delete(); m_cnt = 0; m_pc = 0; m_i1 = NOP; m_i2 = NOP;
    end else if (f) begin
      pend_q.delete(); m_i1 = NOP; m_i2 = NOP;
    end else begin
      if (e_hold && m_cnt < CNT_MAX) m_cnt++;
      if (e_i1 || e_i2) void'(pend_q.pop_front());
      if (e_i1 && e_i2) void'(pend_q.pop_front());
      if (v && e_rdy) begin
        m_pc = pc; m_i1 = a; m_i2 = b;
        pend_q.delete(); pend_q.push_back(2'd1); pend_q.push_back(2'd2);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit s1, input bit s2, input bit d);
    step(0, 0, 0, 32'hdead_beef, $urandom, $urandom, s1, s2, d);
  endtask

  task automatic fetch(input logic [31:0] pc, input bit s1, input bit s2, input bit d);
    step(0, 0, 1, pc, $urandom, $urandom, s1, s2, d);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_pc = 0; m_i1 = NOP; m_i2 = NOP; m_cnt = 0;
    rst = 1; flush = 0; if_valid = 0; if_pc = 0; if_instr_1 = 0; if_instr_2 = 0;
    stall_raw_1 = 0; stall_raw_2 = 0; pair_dep = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state, with spurious hazards that EMPTY must ignore
    idle(1, 1, 1);

    // Back-to-back pairs with no stalls
    fetch(32'h0, 0, 0, 0);
    fetch(32'h8, 0, 0, 0);
    fetch(32'h10, 0, 0, 0);
    idle(0, 0, 0);

    // Slot-1 hazard for two cycles
    fetch(32'h20, 0, 0, 0);
    fetch(32'h28, 1, 0, 0);
    fetch(32'h30, 1, 0, 0);
    idle(0, 0, 0);

    // Pair split, then slot 2 issues alone while the next pair loads
    fetch(32'h40, 0, 0, 0);
    idle(0, 0, 1);
    fetch(32'h48, 1, 0, 1);
    // Slot-2 hazard while HALF
    idle(0, 1, 0);
    idle(0, 1, 0);
    idle(1, 0, 1);
    idle(0, 0, 0);

    // Flush while FULL and holding on slot 1; offered pair must be dropped
    fetch(32'h50, 0, 0, 0);
    idle(1, 0, 0);
    step(0, 1, 1, 32'h60, $urandom, $urandom, 1, 0, 0);
    fetch(32'h70, 0, 0, 0);
    idle(0, 0, 0);

    // Saturation: hold for 20 cycles
    fetch(32'h80, 0, 0, 0);
    for (int i = 0; i < 20; i++) idle(1, $urandom_range(0, 1), $urandom_range(0, 1));
    // Reset overrides a simultaneous flush
    step(1, 1, 1, 32'h90, $urandom, $urandom, 0, 0, 0);
    idle(0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, $urandom & 32'hffff_fff8, $urandom, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_issue_buffer.md
Name: dual_issue_buffer

Overview:
- Decode-stage holding buffer for the dual-issue core. It sits between fetch and the ID/EX pipeline register, directly upstream of the load-use stall generator.
- It holds the current fetched instruction pair and presents both words to the decoder. The decoder derives the source-register numbers that feed the stall generator.
- It consumes stall_raw_1, stall_raw_2 and an intra-pair dependency flag. From these it decides per cycle whether to issue both slots, slot 1 only, or a bubble.
- It back-pressures fetch and supports flush on redirect.

Parameters:
- XLEN, 32, PC width.
- ILEN, 32, instruction word width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  redirect from EX (branch/jump taken); discards buffered pair.
- if_valid  in  1  fetch presents a pair.
- if_pc  in  XLEN  PC of slot 1; slot 2 is at if_pc+4.
- if_instr_1  in  ILEN  instruction at if_pc.
- if_instr_2  in  ILEN  instruction at if_pc+4.
- if_ready  out  1  buffer accepts the pair this cycle.
- dec_pc  out  XLEN  PC of the held pair.
- dec_instr_1  out  ILEN  slot-1 word to decoder.
- dec_instr_2  out  ILEN  slot-2 word to decoder.
- stall_raw_1  in  1  slot-1 load-use hazard from stall generator.
- stall_raw_2  in  1  slot-2 load-use hazard from stall generator.
- pair_dep  in  1  decoder: slot 2 reads slot-1 destination (rd≠x0).
- iss_valid_1  out  1  slot 1 written into ID/EX this cycle.
- iss_valid_2  out  1  slot 2 written into ID/EX this cycle.
- iss_slot2_only  out  1  issued instruction is slot 2 alone, on ID/EX lane 1; PC = dec_pc+4.
- stall_cnt  out  CNT_W  cycles with a held-but-not-issued instruction, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- FSM has three states:
  - EMPTY: nothing held.
  - FULL: both slots pending.
  - HALF: slot 1 already issued, slot 2 pending.
- Reset values:
  - State EMPTY.
  - dec_instr_1/2 = NOP 32'h00000013; dec_pc = 0; stall_cnt = 0.
  - All iss_* = 0.
- Issue outputs are combinational from state and the stall inputs in the same cycle, because the stall generator is combinational on the dec_* regs. State and regs update at the edge.
- EMPTY:
  - iss_* = 0; if_ready = 1.
  - if_valid → load pair, go FULL.
- FULL:
  - stall_raw_1 = 1 → iss_* = 0, hold, if_ready = 0, stall_cnt++.
  - Else if stall_raw_2 or pair_dep → iss_valid_1 = 1, go HALF, if_ready = 0.
  - Else → iss_valid_1 = iss_valid_2 = 1, if_ready = 1. Then if_valid → load, stay FULL; otherwise go EMPTY.
- HALF:
  - pair_dep and stall_raw_1 are ignored.
  - stall_raw_2 = 1 → iss_* = 0, hold, stall_cnt++.
  - Else → iss_valid_2 = 1, iss_slot2_only = 1, if_ready = 1. Load if if_valid → FULL, else EMPTY.
- iss_slot2_only is 1 only in HALF when slot 2 issues.
- flush:
  - Highest priority. Forces iss_* = 0 and if_ready = 0 that cycle.
  - Next state EMPTY, and dec_instr_1/2 reload to NOP.
  - The fetch pair offered in a flush cycle is dropped.
- rst overrides flush.
- stall_cnt:
  - Increments only in FULL/HALF hold cycles without flush.
  - Saturates at all-ones and never wraps.
- Fetch handshake: a pair transfers iff if_valid & if_ready at the edge. if_instr/if_pc are don't-care when if_valid = 0.
- In EMPTY, the dec_* regs keep NOP/stale values. The stall generator may raise stall_raw_* spuriously there; the buffer ignores them.

Decomposition:
- define.v holds the FSM state encodings (ST_EMPTY, ST_FULL, ST_HALF) and the NOP constant.
- It already holds the ALU_L* codes used by the stall generator.
- Single module; no sub-module is warranted. The saturating counter stays inline.

Test Plan:
- Back-to-back pairs: if_valid = 1 continuously with PCs 0x0, 0x8, 0x10 and no stalls. Required: iss_valid_1 = iss_valid_2 = 1 every cycle after the first load, and if_ready constantly 1.
- Slot-1 hazard: FULL, stall_raw_1 = 1 for 2 cycles then 0. Required: two bubble cycles, stall_cnt = 2, then both slots issue, with dec_pc unchanged during the hold.
- Pair split: FULL with pair_dep = 1. Required: cycle 0 iss_valid_1 only. Cycle 1 (HALF) iss_valid_2 = 1 and iss_slot2_only = 1, with if_ready = 1 and the new pair loaded.
- Slot-2 hazard in HALF: stall_raw_2 = 1 for 1 cycle. Required: one bubble, stall_cnt increments, then slot 2 issues alone.
- Flush mid-hold:
  - Setup: FULL with stall_raw_1 = 1, then flush = 1 with if_valid = 1.
  - Required: no issue that cycle and state EMPTY. The fetched pair is dropped, dec_instr = 0x00000013, and the next if_valid pair loads normally.
- Reset and saturation:
  - With CNT_W = 4, hold for 20 cycles. Required: stall_cnt sticks at 15.
  - Then assert rst for one cycle. Required: counter 0, state EMPTY, all iss_* = 0.
